// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core's memory stage and a word-wide, negedge-clocked
// data memory. Sub-word loads are extracted and extended here; sub-word stores use read-modify-write.
module lsu_mem_adapter #(
  parameter int MEM_BITS = 10
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ready,
  output logic        core_done,
  output logic        core_fault,
  output logic [31:0] core_rdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [MEM_BITS+1:0] addr_q;
  logic [2:0]          funct3_q;
  logic                fault_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;

  logic        req_fault;
  logic        accept;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^core_addr[31:MEM_BITS+2];
  assign accept         = (state_q == S_IDLE) && core_valid;

  // Misaligned halfwords/words, reserved encodings and unsigned stores are rejected.
  always_comb begin
    req_fault = 1'b0;
    case (core_funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = core_addr[0];
      3'b010:  req_fault = |core_addr[1:0];
      3'b100:  req_fault = core_we;
      3'b101:  req_fault = core_we | core_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_valid) begin
          if (req_fault) begin
            state_d = S_DONE;
          end else if (!core_we) begin
            state_d = S_RD;
          end else if (core_funct3 == 3'b010) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD:     state_d = S_DONE;
      S_WR:     state_d = S_DONE;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0, then extend.
  always_comb begin
    lane     = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // wdata_q carries the raw store data until RMW_RD replaces it with the merged word.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      fault_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= core_addr[MEM_BITS+1:0];
        funct3_q <= core_funct3;
        fault_q  <= req_fault;
        wdata_q  <= core_wdata;
        if (req_fault && !core_we) begin
          rdata_q <= '0;
        end
      end
      if (state_q == S_RD) begin
        rdata_q <= load_ext;
      end
      if (state_q == S_RMW_RD) begin
        wdata_q <= merged;
      end
    end
  end

  assign core_ready   = (state_q == S_IDLE) && rst;
  assign core_done    = (state_q == S_DONE);
  assign core_fault   = (state_q == S_DONE) && fault_q;
  assign core_rdata   = rdata_q;
  assign mem_read_en  = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign mem_write_en = (state_q == S_WR) || (state_q == S_RMW_WR);
  assign mem_addr     = {{(32-MEM_BITS){1'b0}}, addr_q[MEM_BITS+1:2]};
  assign mem_wdata    = wdata_q;

endmodule
